// File: rtl/pwm_decoder_if.sv
// Pin-side bundle of the PWM decoder: the raw PWM line in, decoded duty and status out.
// The decoder takes the slave view; whatever drives the line and consumes the result takes the master view.
interface pwm_decoder_if;
    logic       pwm_in;
    logic [3:0] duty_code;
    logic       duty_valid;
    logic       stuck;
    logic       overrun;

    modport slave (
        input  pwm_in,
        output duty_code,
        output duty_valid,
        output stuck,
        output overrun
    );

    modport master (
        output pwm_in,
        input  duty_code,
        input  duty_valid,
        input  stuck,
        input  overrun
    );
endinterface

// File: rtl/pwm_decoder.sv
// Measures high time and period of a PWM line and recovers its duty step (0..STEPS)
// through a rounding restoring divider, flagging stuck lines after a timeout.
module pwm_decoder #(
    parameter int CNT_W   = 16,
    parameter int STEPS   = 10,
    parameter int TIMEOUT = 4000
) (
    input  logic         clk,
    input  logic         rst,
    pwm_decoder_if.slave bus
);
    localparam int DVD_W = CNT_W + 4;
    localparam int IT_W  = $clog2(DVD_W);
    localparam logic [IT_W-1:0]  LAST_IT   = IT_W'(DVD_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [DVD_W-1:0] STEPS_W   = DVD_W'(STEPS);
    localparam logic [3:0]       STEPS_C   = 4'(STEPS);

    typedef enum logic {
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              s_dly_q, s_dly_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;
    logic              overrun_q, overrun_d;
    logic              div_busy_q, div_busy_d;
    logic [IT_W-1:0]   it_q, it_d;
    logic [DVD_W-1:0]  dvd_q, dvd_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  divisor_q, divisor_d;

    logic              rise;
    logic              div_done;
    logic [CNT_W:0]    trial;
    logic              ge;
    logic [DVD_W-1:0]  q_full;
    logic [3:0]        q_clamped;

    // One restoring step: the quotient bits shift into the dividend register from the bottom.
    always_comb begin
        rise      = sync2_q & ~s_dly_q;
        div_done  = div_busy_q && (it_q == LAST_IT);
        trial     = {rem_q, dvd_q[DVD_W-1]};
        ge        = (trial >= {1'b0, divisor_q});
        q_full    = {dvd_q[DVD_W-2:0], ge};
        q_clamped = (q_full > STEPS_W) ? STEPS_C : q_full[3:0];
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.pwm_in;
        sync2_d    = sync1_q;
        s_dly_d    = sync2_q;
        hi_d       = hi_q;
        per_d      = per_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        overrun_d  = overrun_q;
        div_busy_d = div_busy_q;
        it_d       = it_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;

        if (div_busy_q) begin
            rem_d = ge ? CNT_W'(trial - {1'b0, divisor_q}) : trial[CNT_W-1:0];
            dvd_d = q_full;
            it_d  = it_q + 1'b1;
            if (div_done) begin
                div_busy_d = 1'b0;
                code_d     = q_clamped;
                valid_d    = 1'b1;
            end
        end

        // A timeout result overrides a divider result finishing in the same cycle.
        case (state_q)
            WAIT_RISE: begin
                hi_d  = '0;
                per_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    stuck_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    stuck_d = 1'b0;
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    if (!div_busy_q || div_done) begin
                        div_busy_d = 1'b1;
                        it_d       = '0;
                        rem_d      = '0;
                        dvd_d      = DVD_W'(hi_q) * STEPS_W + DVD_W'(per_q >> 1);
                        divisor_d  = per_q;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (per_q >= TIMEOUT_C) begin
                    state_d = WAIT_RISE;
                    hi_d    = '0;
                    per_d   = '0;
                    code_d  = sync2_q ? STEPS_C : 4'd0;
                    valid_d = 1'b1;
                    stuck_d = 1'b1;
                end else begin
                    per_d = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
                    if (sync2_q && (hi_q != CNT_MAX)) begin
                        hi_d = hi_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_RISE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            s_dly_q    <= 1'b0;
            hi_q       <= '0;
            per_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            overrun_q  <= 1'b0;
            div_busy_q <= 1'b0;
            it_q       <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            s_dly_q    <= s_dly_d;
            hi_q       <= hi_d;
            per_q      <= per_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            overrun_q  <= overrun_d;
            div_busy_q <= div_busy_d;
            it_q       <= it_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
        end
    end

    assign bus.duty_code  = code_q;
    assign bus.duty_valid = valid_q;
    assign bus.stuck      = stuck_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Drives directed and random PWM waveforms into pwm_decoder and compares every cycle
// against a timestamp-based model of edges, periods and divider latency.
module tb_pwm_decoder;
    localparam int CNT_W   = 16;
    localparam int STEPS   = 10;
    localparam int TIMEOUT = 4000;
    localparam int DIV_LAT = CNT_W + 4;
    localparam int MAXC    = 100000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pwm_decoder_if bus ();

    pwm_decoder #(
        .CNT_W  (CNT_W),
        .STEPS  (STEPS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Reference model: remembers the cycle of each synchronized rising edge and the
    // synchronized level history, and derives results from plain arithmetic on them.
    bit  s_log [0:MAXC-1];
    int  cyc;
    int  last_edge;
    int  div_start;
    int  div_result;
    int  period_m;
    int  high_m;
    bit  started;
    bit  m_sync1, m_sync2, m_sd;
    bit  rise_m, done_now, tmo_now, nxt_valid;
    int  exp_code;
    bit  exp_valid, exp_stuck, exp_over;

    initial begin
        cyc       = 0;
        started   = 1'b0;
        last_edge = -1;
        div_start = -1;
        exp_code  = 0;
        exp_valid = 1'b0;
        exp_stuck = 1'b0;
        exp_over  = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            started   = 1'b1;
            m_sync1   = 1'b0;
            m_sync2   = 1'b0;
            m_sd      = 1'b0;
            last_edge = -1;
            div_start = -1;
            exp_code  = 0;
            exp_valid = 1'b0;
            exp_stuck = 1'b0;
            exp_over  = 1'b0;
        end else begin
            rise_m    = m_sync2 && !m_sd;
            s_log[cyc] = m_sync2;
            nxt_valid = 1'b0;
            done_now  = (div_start >= 0) && (cyc == div_start + DIV_LAT);
            tmo_now   = (last_edge >= 0) && !rise_m && (cyc - last_edge >= TIMEOUT);
            if (done_now) begin
                div_start = -1;
                if (!tmo_now) begin
                    exp_code  = div_result;
                    nxt_valid = 1'b1;
                end
            end
            if (tmo_now) begin
                exp_code  = m_sync2 ? STEPS : 0;
                nxt_valid = 1'b1;
                exp_stuck = 1'b1;
                last_edge = -1;
            end
            if (rise_m) begin
                exp_stuck = 1'b0;
                if (last_edge >= 0) begin
                    period_m = cyc - last_edge;
                    high_m   = 0;
                    for (int c = last_edge; c < cyc; c++) high_m += int'(s_log[c]);
                    if (div_start >= 0) begin
                        exp_over = 1'b1;
                    end else begin
                        div_start  = cyc;
                        div_result = (high_m * STEPS + period_m / 2) / period_m;
                        if (div_result > STEPS) div_result = STEPS;
                    end
                end
                last_edge = cyc;
            end
            exp_valid = nxt_valid;
            m_sd      = m_sync2;
            m_sync2   = m_sync1;
            m_sync1   = bus.pwm_in;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("duty_valid", int'(bus.duty_valid), int'(exp_valid));
            checkOutput("duty_code", int'(bus.duty_code), exp_code);
            checkOutput("stuck", int'(bus.stuck), int'(exp_stuck));
            checkOutput("overrun", int'(bus.overrun), int'(exp_over));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int high, input int period, input int reps);
        for (int r = 0; r < reps; r++) begin
            bus.pwm_in = 1'b1;
            repeat (high) @(negedge clk);
            bus.pwm_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    initial begin
        int p;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.pwm_in = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.pwm_in = ~bus.pwm_in;
            @(negedge clk);
        end
        checkOutput("reset_code", int'(bus.duty_code), 0);
        checkOutput("reset_overrun", int'(bus.overrun), 0);
        rst        = 1'b0;
        bus.pwm_in = 1'b0;
        waitCycles(5);

        applyStimulus(30, 100, 6);
        checkOutput("duty_30pct", int'(bus.duty_code), 3);

        applyStimulus(0, 4100, 1);
        checkOutput("stuck_low_flag", int'(bus.stuck), 1);
        checkOutput("stuck_low_code", int'(bus.duty_code), 0);

        applyStimulus(4100, 4100, 1);
        checkOutput("stuck_high_flag", int'(bus.stuck), 1);
        checkOutput("stuck_high_code", int'(bus.duty_code), 10);

        applyStimulus(99, 100, 4);
        checkOutput("duty_99", int'(bus.duty_code), 10);
        checkOutput("stuck_cleared", int'(bus.stuck), 0);
        applyStimulus(34, 100, 4);
        checkOutput("duty_34", int'(bus.duty_code), 3);
        applyStimulus(35, 100, 4);
        checkOutput("duty_35", int'(bus.duty_code), 4);

        applyStimulus(3, 10, 20);
        checkOutput("overrun_set", int'(bus.overrun), 1);
        checkOutput("overrun_code", int'(bus.duty_code), 3);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("overrun_cleared", int'(bus.overrun), 0);
        waitCycles(5);

        applyStimulus(50, 100, 2);
        bus.pwm_in = 1'b1;
        waitCycles(12);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("midrst_code", int'(bus.duty_code), 0);
        waitCycles(36);
        bus.pwm_in = 1'b0;
        waitCycles(50);
        applyStimulus(50, 100, 3);
        checkOutput("after_midrst", int'(bus.duty_code), 5);

        for (int i = 0; i < 25; i++) begin
            p = int'($urandom_range(5, 200));
            applyStimulus(int'($urandom_range(1, p - 1)), p, int'($urandom_range(1, 4)));
        end
        waitCycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
